// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, register-file write enable and memory request handshake.
module multicycle_control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_cond,
    output logic       reg_write,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_LUI      = 4'd8,
        S_AUIPC    = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11,
        S_JAL      = 4'd12,
        S_JALR     = 4'd13,
        S_JWB      = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    // fetch/branch flag the states whose pc_write/ir_write are gated by live inputs
    typedef struct packed {
        logic       reg_write;
        logic       pc_write;
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       halted;
        logic       fetch;
        logic       branch;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
            end
            S_AUIPC: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.pc_write = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            S_JWB: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.reg_write  = 1'b1;
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_STORE)     state_d = S_MEMWRITE;
                else if (opcode == OP_LOAD) state_d = S_MEMREAD;
                else                        state_d = S_FETCH;
            end
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
                else           state_d = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready) state_d = S_FETCH;
                else           state_d = S_MEMWRITE;
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_JAL, S_JALR:                      state_d = S_JWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JWB:  state_d = S_FETCH;
            S_HALT:                             state_d = S_HALT;
            default:                            state_d = S_FETCH;
        endcase
        ctrl_d = decode_ctrl(state_d);
    end

    // State and output registers; outputs are pre-decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign reg_write  = ctrl_q.reg_write;
    assign pc_write   = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready) | (ctrl_q.branch & branch_cond);
    assign ir_write   = ctrl_q.fetch & mem_ready;
    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign adr_src    = ctrl_q.adr_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign result_src = ctrl_q.result_src;
    assign halted     = ctrl_q.halted;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction sequences plus random traffic,
// both ILLEGAL_HALT settings compared each cycle against a named-phase reference model.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       branch_cond = 1'b0;

    logic       rw1, pw1, iw1, mq1, we1, ad1, hl1;
    logic [1:0] a1, b1, op1, rs1;
    logic       rw0, pw0, iw0, mq0, we0, ad0, hl0;
    logic [1:0] a0, b0, op0, rs0;

    int    passed = 0;
    int    total  = 0;
    string m1 = "FETCH";
    string m0 = "FETCH";

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTY = 7'b0110011;
    localparam logic [6:0] ITY = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] ILL = 7'b1111111;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_cond(branch_cond),
        .reg_write(rw1), .pc_write(pw1), .ir_write(iw1), .mem_req(mq1), .mem_we(we1), .adr_src(ad1),
        .alu_src_a(a1), .alu_src_b(b1), .alu_op(op1), .result_src(rs1), .halted(hl1)
    );

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) dut_skip (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .branch_cond(branch_cond),
        .reg_write(rw0), .pc_write(pw0), .ir_write(iw0), .mem_req(mq0), .mem_we(we0), .adr_src(ad0),
        .alu_src_a(a0), .alu_src_b(b0), .alu_op(op0), .result_src(rs0), .halted(hl0)
    );

    // Expected output vector {reg_write,pc_write,ir_write,mem_req,mem_we,adr_src,a,b,op,result_src,halted}
    function automatic logic [14:0] exp_out(input string s, input logic mr, input logic bc);
        logic rw, pw, iw, mq, we, ad, hl;
        logic [1:0] a, b, op, rs;
        {rw, pw, iw, mq, we, ad, hl} = 7'b0;
        {a, b, op, rs} = 8'b0;
        case (s)
            "FETCH":    begin mq = 1'b1; b = 2'b10; rs = 2'b10; pw = mr; iw = mr; end
            "DECODE":   begin a = 2'b01; b = 2'b01; end
            "MEMADR":   begin a = 2'b10; b = 2'b01; end
            "MEMREAD":  begin mq = 1'b1; ad = 1'b1; end
            "MEMWB":    begin rs = 2'b01; rw = 1'b1; end
            "MEMWRITE": begin mq = 1'b1; we = 1'b1; ad = 1'b1; end
            "EXEC_R":   begin a = 2'b10; b = 2'b00; op = 2'b10; end
            "EXEC_I":   begin a = 2'b10; b = 2'b01; op = 2'b10; end
            "LUI":      begin a = 2'b11; b = 2'b01; end
            "AUIPC":    begin a = 2'b01; b = 2'b01; end
            "ALUWB":    begin rw = 1'b1; end
            "BRANCH":   begin a = 2'b10; op = 2'b01; pw = bc; end
            "JAL":      begin pw = 1'b1; end
            "JALR":     begin a = 2'b10; b = 2'b01; rs = 2'b10; pw = 1'b1; end
            "JWB":      begin a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1'b1; end
            "HALT":     begin hl = 1'b1; end
            default:    begin hl = 1'bx; end
        endcase
        return {rw, pw, iw, mq, we, ad, a, b, op, rs, hl};
    endfunction

    function automatic string nxt(input string s, input logic [6:0] op, input logic mr, input bit ih);
        case (s)
            "FETCH":    return mr ? "DECODE" : "FETCH";
            "DECODE": begin
                case (op)
                    LOAD, STORE: return "MEMADR";
                    RTY:   return "EXEC_R";
                    ITY:   return "EXEC_I";
                    BR:    return "BRANCH";
                    JAL:   return "JAL";
                    JALR:  return "JALR";
                    LUI:   return "LUI";
                    AUIPC: return "AUIPC";
                    default: return ih ? "HALT" : "FETCH";
                endcase
            end
            "MEMADR":   return (op == STORE) ? "MEMWRITE" : ((op == LOAD) ? "MEMREAD" : "FETCH");
            "MEMREAD":  return mr ? "MEMWB" : "MEMREAD";
            "MEMWRITE": return mr ? "FETCH" : "MEMWRITE";
            "EXEC_R", "EXEC_I", "LUI", "AUIPC": return "ALUWB";
            "JAL", "JALR": return "JWB";
            "HALT":     return "HALT";
            default:    return "FETCH";
        endcase
    endfunction

    task automatic check(input string tag);
        logic [14:0] o1, o0, e1, e0;
        o1 = {rw1, pw1, iw1, mq1, we1, ad1, a1, b1, op1, rs1, hl1};
        o0 = {rw0, pw0, iw0, mq0, we0, ad0, a0, b0, op0, rs0, hl0};
        e1 = exp_out(m1, mem_ready, branch_cond);
        e0 = exp_out(m0, mem_ready, branch_cond);
        total++;
        assert (o1 === e1) passed++;
        else $error("FAIL %s[halt,%s]: observed %b expected %b", tag, m1, o1, e1);
        total++;
        assert (o0 === e0) passed++;
        else $error("FAIL %s[skip,%s]: observed %b expected %b", tag, m0, o0, e0);
    endtask

    // One clock: drive inputs, check mid-cycle, advance the model with the DUT
    task automatic cycle(input logic [6:0] op, input logic mr, input logic bc, input string tag);
        opcode = op; mem_ready = mr; branch_cond = bc;
        @(negedge clk);
        check(tag);
        @(posedge clk);
        m1 = nxt(m1, op, mr, 1'b1);
        m0 = nxt(m0, op, mr, 1'b0);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m1 = "FETCH";
        m0 = "FETCH";
        check(tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [10] = '{LOAD, STORE, RTY, ITY, BR, JAL, JALR, LUI, AUIPC, ILL};
    logic [6:0] cur_op;
    logic [14:0] rst_vec;

    initial begin
        mem_ready = 1'b0;
        #2;
        apply_reset("reset");
        rst_vec = 15'b000100_00_10_00_10_0;
        total++;
        assert ({rw1, pw1, iw1, mq1, we1, ad1, a1, b1, op1, rs1, hl1} === rst_vec) passed++;
        else $error("FAIL reset_const: observed %b expected %b", {rw1, pw1, iw1, mq1, we1, ad1, a1, b1, op1, rs1, hl1}, rst_vec);

        repeat (5) cycle(RTY, 1'b1, 1'b0, "rtype");
        repeat (3) cycle(LOAD, 1'b0, 1'b0, "load_fetch_wait");
        repeat (3) cycle(LOAD, 1'b1, 1'b0, "load_addr");
        repeat (2) cycle(LOAD, 1'b0, 1'b0, "load_memread_wait");
        repeat (3) cycle(LOAD, 1'b1, 1'b0, "load_wb");
        repeat (5) cycle(STORE, 1'b1, 1'b0, "store");
        repeat (4) cycle(BR, 1'b1, 1'b1, "branch_taken");
        repeat (4) cycle(BR, 1'b1, 1'b0, "branch_not_taken");
        repeat (4) cycle(JALR, 1'b1, 1'b0, "jalr");
        repeat (4) cycle(JAL, 1'b1, 1'b0, "jal");
        repeat (4) cycle(LUI, 1'b1, 1'b0, "lui");
        repeat (4) cycle(AUIPC, 1'b1, 1'b0, "auipc");
        repeat (4) cycle(ITY, 1'b1, 1'b0, "itype");
        repeat (14) cycle(ILL, 1'b1, 1'b1, "illegal");
        apply_reset("reset_after_halt");

        repeat (3) cycle(STORE, 1'b1, 1'b0, "store_pre");
        cycle(STORE, 1'b0, 1'b0, "store_memwrite");
        apply_reset("reset_mid_memwrite");
        total++;
        assert (we1 === 1'b0 && mq1 === 1'b1) passed++;
        else $error("FAIL reset_mid_memwrite_we: observed we=%b req=%b expected we=0 req=1", we1, mq1);

        cur_op = RTY;
        for (int i = 0; i < 3000; i++) begin
            if (m1 == "HALT" && $urandom_range(0, 3) == 0) begin
                apply_reset("rand_reset");
            end else begin
                if (m1 == "FETCH" && m0 == "FETCH") begin
                    if ($urandom_range(0, 12) < 10) cur_op = ops[$urandom_range(0, 9)];
                    else cur_op = 7'($urandom_range(0, 127));
                end
                cycle(cur_op, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), "random");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sits directly upstream of the register file and drives its write enable (reg_write connects to write_enable_flag).
- Sequences fetch, decode, execute, memory access and writeback.
- Generates the datapath mux selects and the memory request handshake. The datapath holds the instruction, PC, old PC and ALUOut registers.

Parameters:
- ILLEGAL_HALT, 1, 1: an unsupported opcode enters HALT. 0: an unsupported opcode returns to FETCH (instruction skipped).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- mem_ready  in  1  memory completes the current request this cycle
- branch_cond  in  1  ALU branch comparison true (evaluated in BRANCH)
- reg_write  out  1  register-file write enable
- pc_write  out  1  PC register load
- ir_write  out  1  instruction-register and old-PC load
- mem_req  out  1  memory request
- mem_we  out  1  memory write (valid with mem_req)
- adr_src  out  1  0 = PC, 1 = ALUOut
- alu_src_a  out  2  00 PC, 01 OLDPC, 10 RS1, 11 ZERO
- alu_src_b  out  2  00 RS2, 01 IMM, 10 FOUR
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
- halted  out  1  FSM in HALT

Behaviour:
- One clock. Reset is asynchronous and active-low. rst_n low forces state = FETCH immediately, mid-instruction included. An in-flight memory request is abandoned; the memory must tolerate mem_req dropping.
- Moore FSM; state register only. Outputs decode from state, with mem_ready/branch_cond gating where noted.
- Outputs not listed for a state are 0 / 00.
- Reset values (state FETCH): mem_req=1, alu_src_b=10, result_src=10; all else 0.
- FETCH: mem_req=1, adr_src=0, a=PC, b=FOUR, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - mem_ready -> DECODE, else stay. The wait is unbounded.
- DECODE: a=OLDPC, b=IMM, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> HALT if ILLEGAL_HALT, else FETCH
- MEMADR: a=RS1, b=IMM, alu_op=00. Load -> MEMREAD, store -> MEMWRITE. The opcode is held stable by the IR.
- MEMREAD: mem_req=1, adr_src=1. mem_ready -> MEMWB, else stay.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. mem_ready -> FETCH, else stay.
- EXEC_R: a=RS1, b=RS2, alu_op=10 -> ALUWB.
- EXEC_I: a=RS1, b=IMM, alu_op=10 -> ALUWB.
- LUI: a=ZERO, b=IMM, alu_op=00 -> ALUWB.
- AUIPC: a=OLDPC, b=IMM, alu_op=00 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=RS1, b=RS2, alu_op=01, result_src=00, pc_write=branch_cond -> FETCH.
- JAL: result_src=00, pc_write=1 -> JWB.
- JALR: a=RS1, b=IMM, alu_op=00, result_src=10, pc_write=1 -> JWB.
- JWB: a=OLDPC, b=FOUR, alu_op=00, result_src=10, reg_write=1 -> FETCH. The PC is written before rd, so rd==rs1 is safe.
- HALT: halted=1, all other outputs 0, stay until reset.
- reg_write is high only in MEMWB, ALUWB and JWB, for exactly one cycle per instruction. The rd==x0 discard is handled by the register file.
- mem_req is never asserted outside FETCH, MEMREAD and MEMWRITE.
- Encode states in 4 bits. Unreachable codes -> FETCH.

Test Plan:
- Reset low for 2 cycles, release with mem_ready=1, opcode=0110011 -> states FETCH, DECODE, EXEC_R, ALUWB, FETCH. reg_write=1 only in cycle 4; pc_write/ir_write=1 in cycle 1.
- Load (0000011), mem_ready low for 3 cycles in FETCH and 2 cycles in MEMREAD -> FETCH held 4 cycles; MEMREAD held 3 cycles with adr_src=1, mem_we=0; then MEMWB with result_src=01, reg_write=1.
- Store (0100011), mem_ready=1 -> MEMADR then MEMWRITE with mem_req=1, mem_we=1 for 1 cycle; reg_write never asserted.
- Branch (1100011): branch_cond=1 -> pc_write=1 in BRANCH; rerun with branch_cond=0 -> pc_write=0; both return to FETCH after 3 cycles.
- JALR (1100111) -> JALR with pc_write=1, a=10, b=01; then JWB with reg_write=1, a=01, b=10.
- Illegal opcode 1111111: ILLEGAL_HALT=1 -> halted=1 and all outputs 0 for 10+ cycles. ILLEGAL_HALT=0 -> back to FETCH. Asserting rst_n low mid-MEMWRITE -> immediate FETCH, mem_we=0.
